// File: rtl/any1_agen_stream.sv
// Address-generation stream: turns one scalar/indexed/strided request into a
// sequence of effective addresses delivered over a valid/ready handshake.
module any1_agen_stream #(
  parameter int unsigned AWID  = 32,
  parameter int unsigned VLMAX = 64,
  parameter int unsigned ELW   = $clog2(VLMAX) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      mode,
  input  logic [1:0]      sc,
  input  logic [1:0]      size,
  input  logic [AWID-1:0] base,
  input  logic [AWID-1:0] disp,
  input  logic [AWID-1:0] idx,
  input  logic [AWID-1:0] stride,
  input  logic [ELW-1:0]  vlen,
  output logic            ea_valid,
  input  logic            ea_ready,
  output logic [AWID-1:0] ea,
  output logic [ELW-2:0]  ea_elem,
  output logic            ea_last,
  output logic            ea_misalign,
  input  logic            abort,
  output logic            busy
);

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AWID-1:0] ea_q, ea_d;
  logic [AWID-1:0] stride_q, stride_d;
  logic [ELW-2:0]  elem_q, elem_d;
  logic [ELW-2:0]  lastidx_q, lastidx_d;
  logic            last_q, last_d;
  logic [1:0]      size_q, size_d;

  logic            accept;
  logic            is_strided;
  logic            zero_len;
  logic [AWID-1:0] idx_term;
  logic [AWID-1:0] first_ea;
  logic [ELW-1:0]  n_clip;
  logic [ELW-2:0]  n_m1;
  logic [ELW-2:0]  elem_inc;
  logic [2:0]      low_mask;

  // Request decode: first address and clipped beat count.
  always_comb begin
    is_strided = (mode == 2'd2);
    idx_term   = (mode == 2'd1) ? (idx << sc) : '0;
    first_ea   = base + disp + idx_term;
    n_clip     = (vlen > ELW'(VLMAX)) ? ELW'(VLMAX) : vlen;
    n_m1       = (ELW-1)'(n_clip - ELW'(1));
    zero_len   = is_strided && (vlen == '0);
    accept     = req_valid && (state_q == IDLE);
    elem_inc   = elem_q + (ELW-1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ea_q      <= '0;
      stride_q  <= '0;
      elem_q    <= '0;
      lastidx_q <= '0;
      last_q    <= 1'b0;
      size_q    <= '0;
    end else begin
      state_q   <= state_d;
      ea_q      <= ea_d;
      stride_q  <= stride_d;
      elem_q    <= elem_d;
      lastidx_q <= lastidx_d;
      last_q    <= last_d;
      size_q    <= size_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ea_d      = ea_q;
    stride_d  = stride_q;
    elem_d    = elem_q;
    lastidx_d = lastidx_q;
    last_d    = last_q;
    size_d    = size_q;
    unique case (state_q)
      IDLE: begin
        // A zero-length strided request is consumed without leaving IDLE.
        if (accept && !zero_len) begin
          state_d   = GEN;
          ea_d      = first_ea;
          stride_d  = stride;
          size_d    = size;
          elem_d    = '0;
          lastidx_d = is_strided ? n_m1 : '0;
          last_d    = !is_strided || (n_m1 == '0);
        end
      end
      GEN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (ea_ready) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            ea_d   = ea_q + stride_q;
            elem_d = elem_inc;
            last_d = (elem_inc == lastidx_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    unique case (size_q)
      2'd0:    low_mask = 3'b000;
      2'd1:    low_mask = 3'b001;
      2'd2:    low_mask = 3'b011;
      default: low_mask = 3'b111;
    endcase
    req_ready   = (state_q == IDLE);
    busy        = (state_q == GEN);
    ea_valid    = (state_q == GEN);
    ea          = ea_q;
    ea_elem     = elem_q;
    ea_last     = last_q;
    ea_misalign = |(ea_q[2:0] & low_mask);
  end

endmodule
